ssp_write_packer: RTL

- Upstream feeder for the parallel-write scratchpad.
- Accepts a single-word valid/ready stream and packs PAR_WRITE consecutive words into one wide write (wen/waddr/din).
- Manages a circular write pointer over the scratchpad and tracks occupancy against consumer releases, so unread entries are never overwritten.
- Sits between the input word source and the scratchpad write port.

---
 rtl/ssp_write_packer.sv | 103 ++++++++++
 1 files changed

// File: rtl/ssp_write_packer.sv
// ssp_write_packer: packs PAR_WRITE stream words into one wide scratchpad write with occupancy tracking.
// Define SSP_WP_STALL_CNT_EN to add the saturating stall_cycles counter output.
module ssp_write_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int PAR_WRITE  = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH-1:0]           in_data,
    input  logic                            in_last,
    input  logic                            release_valid,
    input  logic [ADDR_WIDTH:0]             release_count,
    output logic                            wen,
    output logic                            chip_en,
    output logic [ADDR_WIDTH-1:0]           waddr,
    output logic [PAR_WRITE*DATA_WIDTH-1:0] din,
    output logic [ADDR_WIDTH:0]             occupancy,
    output logic                            full,
    output logic                            done,
    output logic                            err
`ifdef SSP_WP_STALL_CNT_EN
    ,
    output logic [15:0]                     stall_cycles
`endif
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LW = PAR_WRITE > 1 ? $clog2(PAR_WRITE) : 1;
    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;
    localparam logic [ADDR_WIDTH:0] OCC_LIMIT = (ADDR_WIDTH + 1)'(DEPTH - PAR_WRITE);

    if (PAR_WRITE < 1 || DEPTH % PAR_WRITE != 0) begin : g_bad_par
        $fatal(1, "PAR_WRITE must divide DEPTH");
    end

    logic [0:0]                      state;
    logic [LW-1:0]                   lane;
    logic [PAR_WRITE*DATA_WIDTH-1:0] pack, din_q;
    logic                            last_q;
    logic [ADDR_WIDTH-1:0]           wr_ptr, waddr_q;
    logic [ADDR_WIDTH:0]             occ, occ_add, occ_sub;

    // Outputs depend only on registered state; waddr/din replay the last write while idle.
    always_comb begin
        in_ready = state == COLLECT;
        wen = state == ISSUE && occ <= OCC_LIMIT;
        chip_en = wen;
        done = wen && last_q;
        full = occ > OCC_LIMIT;
        occupancy = occ;
        waddr = wen ? wr_ptr : waddr_q;
        din = wen ? pack : din_q;
        occ_add = occ + (wen ? (ADDR_WIDTH + 1)'(PAR_WRITE) : '0);
        occ_sub = release_valid ? release_count : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
            lane <= '0;
            pack <= '0;
            last_q <= 1'b0;
            wr_ptr <= '0;
            waddr_q <= '0;
            din_q <= '0;
            occ <= '0;
            err <= 1'b0;
        end else begin
            if (state == COLLECT && in_valid) begin
                pack[lane*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                lane <= lane + 1'b1;
                last_q <= in_last;
                if (lane == LW'(PAR_WRITE - 1) || in_last) state <= ISSUE;
            end
            if (wen) begin
                state <= COLLECT;
                lane <= '0;
                pack <= '0;
                last_q <= 1'b0;
                wr_ptr <= wr_ptr + ADDR_WIDTH'(PAR_WRITE);
                waddr_q <= wr_ptr;
                din_q <= pack;
            end
            // Over-release clamps to empty and latches the error until reset.
            if (occ_sub > occ_add) begin
                occ <= '0;
                err <= 1'b1;
            end else begin
                occ <= occ_add - occ_sub;
            end
        end
    end

`ifdef SSP_WP_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) stall_cycles <= '0;
        else if (state == ISSUE && !wen && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
    end
`endif
endmodule
